keyboard_nespad_ostimer: RTL and testbench

KEYBOARD_NESPAD_OSTIMER -- requirements
Module: keyboard_nespad_ostimer

---
 rtl/keyboard_nespad_ostimer.sv | 257 +++++++++++++++++++++++++
 tb/tb_keyboard_nespad_ostimer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_nespad_ostimer.sv
// keyboard_nespad_ostimer
//   Three small peripherals sharing one clock and reset:
//   - PS/2 keyboard receiver: synchronizes and filters ps2c, shifts in
//     11-bit frames on filtered falling edges, presents the scan code.
//   - NES/SNES pad poller: free-running latch/clock sequence, 16 bits per
//     poll, results published atomically.
//   - One-shot millisecond timer with a single-cycle interrupt pulse.
//
// Ports
//   clk, reset          system clock (rising edge), synchronous active-high reset
//   ps2c, ps2d          PS/2 clock/data, asynchronous
//   rx_en               keyboard receive enable (checked at frame start)
//   rx_done_tick        one-cycle pulse when rx_data holds a new scan code
//   rx_data[7:0]        last received scan code
//   nesc, nesl          pad clock / latch outputs
//   nesd                pad serial data, active low
//   nes_state[15:0]     button bitmap, 1 = pressed, bit 0 = first bit read
//   timer_value[31:0]   timer load value in milliseconds
//   set_value, trigger  store timer_value / start the countdown
//   interrupt           one-cycle pulse when the countdown expires
//
// States
//   KB_IDLE   | waiting for a start-bit strobe with rx_en=1
//   KB_RECV   | shifting in the remaining 10 bits of the frame
//   KB_DONE   | scan code valid, rx_done_tick high for this cycle
//   NES_IDLE  | nesc=1, nesl=0, waiting for the poll counter
//   NES_LATCH | nesl=1 for 2*NES_HALF cycles
//   NES_HIGH  | nesc=1 for NES_HALF cycles, nesd sampled on the last one
//   NES_LOW   | nesc=0 for NES_HALF cycles
module keyboard_nespad_ostimer #(
  parameter int unsigned CLKS_PER_MS = 25000,
  parameter int unsigned NES_HALF    = 150,
  parameter int unsigned NES_POLL    = 25000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2c,
  input  logic        ps2d,
  input  logic        rx_en,
  output logic        rx_done_tick,
  output logic [7:0]  rx_data,
  output logic        nesc,
  output logic        nesl,
  input  logic        nesd,
  output logic [15:0] nes_state,
  input  logic [31:0] timer_value,
  input  logic        set_value,
  input  logic        trigger,
  output logic        interrupt
);

  localparam int unsigned PW  = (NES_POLL > 1)     ? $clog2(NES_POLL)     : 1;
  localparam int unsigned TW  = (2*NES_HALF > 1)   ? $clog2(2*NES_HALF)   : 1;
  localparam int unsigned PRW = (CLKS_PER_MS > 1)  ? $clog2(CLKS_PER_MS)  : 1;

  // ---------------- keyboard ----------------
  typedef enum logic [1:0] {KB_IDLE, KB_RECV, KB_DONE} kb_state_e;

  logic [1:0] ps2c_sync_q, ps2c_sync_d, ps2d_sync_q, ps2d_sync_d;
  logic [7:0] filt_q, filt_d;
  logic       fclk_q, fclk_d;
  kb_state_e  kb_state_q, kb_state_d;
  logic [3:0] kb_cnt_q, kb_cnt_d;
  logic [8:0] kb_sr_q, kb_sr_d;    // last 9 bits; start bit falls off the end
  logic [7:0] rx_data_q, rx_data_d;
  logic       strobe;

  always_comb begin
    ps2c_sync_d = {ps2c_sync_q[0], ps2c};
    ps2d_sync_d = {ps2d_sync_q[0], ps2d};
    filt_d      = {filt_q[6:0], ps2c_sync_q[1]};
    fclk_d      = fclk_q;
    if (filt_q == 8'hFF)      fclk_d = 1'b1;
    else if (filt_q == 8'h00) fclk_d = 1'b0;
  end

  assign strobe = fclk_q & ~fclk_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      ps2c_sync_q <= 2'b11;
      ps2d_sync_q <= 2'b11;
      filt_q      <= 8'hFF;
      fclk_q      <= 1'b1;
      kb_state_q  <= KB_IDLE;
      kb_cnt_q    <= '0;
      kb_sr_q     <= '0;
      rx_data_q   <= '0;
    end else begin
      ps2c_sync_q <= ps2c_sync_d;
      ps2d_sync_q <= ps2d_sync_d;
      filt_q      <= filt_d;
      fclk_q      <= fclk_d;
      kb_state_q  <= kb_state_d;
      kb_cnt_q    <= kb_cnt_d;
      kb_sr_q     <= kb_sr_d;
      rx_data_q   <= rx_data_d;
    end
  end

  always_comb begin
    kb_state_d = kb_state_q;
    kb_cnt_d   = kb_cnt_q;
    kb_sr_d    = kb_sr_q;
    rx_data_d  = rx_data_q;
    case (kb_state_q)
      KB_IDLE: if (strobe && rx_en) begin
        kb_state_d = KB_RECV;
        kb_cnt_d   = 4'd1;
        kb_sr_d    = {ps2d_sync_q[1], kb_sr_q[8:1]};
      end
      KB_RECV: if (strobe) begin
        kb_sr_d  = {ps2d_sync_q[1], kb_sr_q[8:1]};
        kb_cnt_d = kb_cnt_q + 4'd1;
        // 11th strobe is the stop bit; d7..d0 already sit in the low byte
        if (kb_cnt_q == 4'd10) begin
          kb_state_d = KB_DONE;
          rx_data_d  = kb_sr_q[7:0];
        end
      end
      default: kb_state_d = KB_IDLE;
    endcase
  end

  always_comb begin
    rx_done_tick = (kb_state_q == KB_DONE);
    rx_data      = rx_data_q;
  end

  // ---------------- NES pad ----------------
  typedef enum logic [1:0] {NES_IDLE, NES_LATCH, NES_HIGH, NES_LOW} nes_state_e;

  logic [PW-1:0] poll_q, poll_d;
  nes_state_e    nes_st_q, nes_st_d;
  logic [TW-1:0] nes_tmr_q, nes_tmr_d;
  logic [3:0]    nes_bit_q, nes_bit_d;
  logic [15:0]   shadow_q, shadow_d, nes_state_q, nes_state_d;
  logic          poll_start;

  assign poll_start = (poll_q == '0);
  assign poll_d     = poll_start ? PW'(NES_POLL - 1) : poll_q - PW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      poll_q      <= '0;
      nes_st_q    <= NES_IDLE;
      nes_tmr_q   <= '0;
      nes_bit_q   <= '0;
      shadow_q    <= '0;
      nes_state_q <= '0;
    end else begin
      poll_q      <= poll_d;
      nes_st_q    <= nes_st_d;
      nes_tmr_q   <= nes_tmr_d;
      nes_bit_q   <= nes_bit_d;
      shadow_q    <= shadow_d;
      nes_state_q <= nes_state_d;
    end
  end

  always_comb begin
    nes_st_d    = nes_st_q;
    nes_tmr_d   = (nes_tmr_q == '0) ? nes_tmr_q : nes_tmr_q - TW'(1);
    nes_bit_d   = nes_bit_q;
    shadow_d    = shadow_q;
    nes_state_d = nes_state_q;
    case (nes_st_q)
      NES_IDLE: if (poll_start) begin
        nes_st_d  = NES_LATCH;
        nes_tmr_d = TW'(2*NES_HALF - 1);
      end
      NES_LATCH: if (nes_tmr_q == '0) begin
        nes_st_d  = NES_HIGH;
        nes_tmr_d = TW'(NES_HALF - 1);
        nes_bit_d = '0;
      end
      NES_HIGH: if (nes_tmr_q == '0) begin
        shadow_d[nes_bit_q] = ~nesd;
        nes_st_d  = NES_LOW;
        nes_tmr_d = TW'(NES_HALF - 1);
      end
      NES_LOW: if (nes_tmr_q == '0) begin
        if (nes_bit_q == 4'd15) begin
          nes_st_d    = NES_IDLE;
          nes_state_d = shadow_q;
        end else begin
          nes_st_d  = NES_HIGH;
          nes_bit_d = nes_bit_q + 4'd1;
          nes_tmr_d = TW'(NES_HALF - 1);
        end
      end
      default: nes_st_d = NES_IDLE;
    endcase
  end

  always_comb begin
    nesl      = (nes_st_q == NES_LATCH);
    nesc      = (nes_st_q != NES_LOW);
    nes_state = nes_state_q;
  end

  // ---------------- OS timer ----------------
  logic [31:0]    stored_q, stored_d, cnt_q, cnt_d;
  logic [PRW-1:0] pre_q, pre_d;
  logic           run_q, run_d, zero_q, zero_d;
  logic           tc;

  always_ff @(posedge clk) begin
    if (reset) begin
      stored_q <= '0;
      cnt_q    <= '0;
      pre_q    <= '0;
      run_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      stored_q <= stored_d;
      cnt_q    <= cnt_d;
      pre_q    <= pre_d;
      run_q    <= run_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    stored_d = set_value ? timer_value : stored_q;
    cnt_d    = cnt_q;
    pre_d    = pre_q;
    run_d    = run_q;
    zero_d   = 1'b0;
    if (trigger) begin
      // stored_d already carries a same-cycle set_value
      if (stored_d == 32'd0) begin
        run_d  = 1'b0;
        cnt_d  = '0;
        zero_d = 1'b1;
      end else begin
        run_d = 1'b1;
        cnt_d = stored_d;
        pre_d = PRW'(CLKS_PER_MS - 1);
      end
    end else if (run_q) begin
      if (pre_q == '0) begin
        pre_d = PRW'(CLKS_PER_MS - 1);
        cnt_d = cnt_q - 32'd1;
        if (cnt_q == 32'd1) run_d = 1'b0;
      end else begin
        pre_d = pre_q - PRW'(1);
      end
    end
  end

  // Terminal count is decoded from the flops so the pulse lands on the
  // N*CLKS_PER_MS-th cycle rather than one cycle later.
  assign tc        = run_q && (pre_q == '0) && (cnt_q == 32'd1);
  assign interrupt = ~reset & (zero_q | tc);

endmodule

// File: tb/tb_keyboard_nespad_ostimer.sv
module tb_keyboard_nespad_ostimer;
  localparam int CPM = 10, HALF = 4, POLL = 400;

  logic        clk = 1'b0;
  logic        reset, ps2c, ps2d, rx_en, nesd, set_value, trigger;
  logic [31:0] timer_value;
  logic        rx_done_tick, nesc, nesl, interrupt;
  logic [7:0]  rx_data;
  logic [15:0] nes_state;

  keyboard_nespad_ostimer #(.CLKS_PER_MS(CPM), .NES_HALF(HALF), .NES_POLL(POLL)) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
    .rx_done_tick(rx_done_tick), .rx_data(rx_data), .nesc(nesc), .nesl(nesl),
    .nesd(nesd), .nes_state(nes_state), .timer_value(timer_value),
    .set_value(set_value), .trigger(trigger), .interrupt(interrupt));

  always #5 clk = ~clk;

  int pass_cnt = 0, total_cnt = 0;

  // free-running monitors and pad model, all on the falling edge
  int          tick_total = 0, nesl_total = 0, nesc_fall_total = 0;
  logic        nesc_prev = 1'b1;
  logic [15:0] pad_pattern = 16'h8001;
  logic [4:0]  pad_idx = '0;
  assign nesd = ~pad_pattern[pad_idx[3:0]];

  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) tick_total++;
    if (nesl === 1'b1) nesl_total++;
    if (nesc_prev === 1'b1 && nesc === 1'b0) nesc_fall_total++;
    if (nesl === 1'b1) pad_idx <= '0;
    else if (nesc === 1'b1 && nesc_prev === 1'b0) pad_idx <= pad_idx + 5'd1;
    nesc_prev <= nesc;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2d = f[i];
      tick(40);
      ps2c = 1'b0;
      tick(40);
      ps2c = 1'b1;
    end
    tick(40);
  endtask

  // trigger was driven for the cycle just before this call; k counts cycles after it
  task automatic observe(input int window, input int retrig_at, input int setv_at,
                         input logic [31:0] setv, input int rst_at,
                         output int first, output int pulses);
    first = -1;
    pulses = 0;
    for (int k = 1; k <= window; k++) begin
      @(posedge clk);
      #1;
      trigger = 1'b0;
      set_value = 1'b0;
      reset = 1'b0;
      if (interrupt === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
      if (k == retrig_at) trigger = 1'b1;
      if (k == setv_at) begin set_value = 1'b1; timer_value = setv; end
      if (k == rst_at || k == rst_at + 1) reset = 1'b1;
    end
  endtask

  task automatic arm(input logic do_set, input logic [31:0] v, input logic same_cycle);
    if (do_set && !same_cycle) begin
      set_value = 1'b1; timer_value = v;
      tick(1);
      set_value = 1'b0;
    end
    if (do_set && same_cycle) begin set_value = 1'b1; timer_value = v; end
    trigger = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b0;
    set_value = 1'b0; trigger = 1'b0; timer_value = '0;
    tick(4);
    total_cnt += 6;
    if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data); else pass_cnt++;
    if (rx_done_tick !== 1'b0) $display("FAIL reset_rx_done_tick: got %b expected 0", rx_done_tick); else pass_cnt++;
    if (nes_state !== 16'h0000) $display("FAIL reset_nes_state: got %h expected 0000", nes_state); else pass_cnt++;
    if (nesc !== 1'b1) $display("FAIL reset_nesc: got %b expected 1", nesc); else pass_cnt++;
    if (nesl !== 1'b0) $display("FAIL reset_nesl: got %b expected 0", nesl); else pass_cnt++;
    if (interrupt !== 1'b0) $display("FAIL reset_interrupt: got %b expected 0", interrupt); else pass_cnt++;
  endtask

  task automatic test_pad();
    int sl, sc;
    sl = nesl_total;
    sc = nesc_fall_total;
    reset = 1'b0;
    tick(100);
    total_cnt++;
    if (nes_state !== 16'h0000) $display("FAIL pad_partial_hidden: got %h expected 0000", nes_state); else pass_cnt++;
    tick(100);
    total_cnt += 3;
    if (nes_state !== 16'h8001) $display("FAIL pad_state: got %h expected 8001", nes_state); else pass_cnt++;
    if (nesl_total - sl !== 8) $display("FAIL pad_nesl_width: got %0d expected 8", nesl_total - sl); else pass_cnt++;
    if (nesc_fall_total - sc !== 16) $display("FAIL pad_nesc_pulses: got %0d expected 16", nesc_fall_total - sc); else pass_cnt++;
  endtask

  task automatic test_keyboard();
    int s;
    rx_en = 1'b1;
    tick(20);
    s = tick_total;
    send_frame(8'h1C);
    total_cnt += 2;
    if (tick_total - s !== 1) $display("FAIL kb_1c_ticks: got %0d expected 1", tick_total - s); else pass_cnt++;
    if (rx_data !== 8'h1C) $display("FAIL kb_1c_data: got %h expected 1c", rx_data); else pass_cnt++;
    s = tick_total;
    send_frame(8'hF0);
    total_cnt += 2;
    if (tick_total - s !== 1) $display("FAIL kb_f0_ticks: got %0d expected 1", tick_total - s); else pass_cnt++;
    if (rx_data !== 8'hF0) $display("FAIL kb_f0_data: got %h expected f0", rx_data); else pass_cnt++;
  endtask

  task automatic test_kb_disabled_glitch();
    int s;
    rx_en = 1'b0;
    s = tick_total;
    send_frame(8'h1C);
    total_cnt += 2;
    if (tick_total - s !== 0) $display("FAIL kb_disabled_ticks: got %0d expected 0", tick_total - s); else pass_cnt++;
    if (rx_data !== 8'hF0) $display("FAIL kb_disabled_data: got %h expected f0", rx_data); else pass_cnt++;
    rx_en = 1'b1;
    ps2c = 1'b0;
    tick(5);
    ps2c = 1'b1;
    tick(40);
    s = tick_total;
    send_frame(8'h5A);
    total_cnt += 2;
    if (tick_total - s !== 1) $display("FAIL kb_glitch_ticks: got %0d expected 1", tick_total - s); else pass_cnt++;
    if (rx_data !== 8'h5A) $display("FAIL kb_glitch_data: got %h expected 5a", rx_data); else pass_cnt++;
  endtask

  task automatic test_timer_basic();
    int first, pulses;
    arm(1'b1, 32'd3, 1'b0);
    observe(60, -5, -5, '0, -5, first, pulses);
    total_cnt += 2;
    if (first !== 30) $display("FAIL tmr3_delay: got %0d expected 30", first); else pass_cnt++;
    if (pulses !== 1) $display("FAIL tmr3_pulses: got %0d expected 1", pulses); else pass_cnt++;
    arm(1'b1, 32'd0, 1'b0);
    observe(20, -5, -5, '0, -5, first, pulses);
    total_cnt += 2;
    if (first !== 1) $display("FAIL tmr0_delay: got %0d expected 1", first); else pass_cnt++;
    if (pulses !== 1) $display("FAIL tmr0_pulses: got %0d expected 1", pulses); else pass_cnt++;
    arm(1'b1, 32'd2, 1'b1);
    observe(40, -5, -5, '0, -5, first, pulses);
    total_cnt += 2;
    if (first !== 20) $display("FAIL tmr_same_cycle_delay: got %0d expected 20", first); else pass_cnt++;
    if (pulses !== 1) $display("FAIL tmr_same_cycle_pulses: got %0d expected 1", pulses); else pass_cnt++;
  endtask

  task automatic test_retrigger();
    int first, pulses;
    arm(1'b1, 32'd3, 1'b0);
    observe(80, 15, -5, '0, -5, first, pulses);
    total_cnt += 2;
    if (first !== 45) $display("FAIL retrig_delay: got %0d expected 45", first); else pass_cnt++;
    if (pulses !== 1) $display("FAIL retrig_pulses: got %0d expected 1", pulses); else pass_cnt++;
  endtask

  task automatic test_set_while_running();
    int first, pulses;
    arm(1'b1, 32'd3, 1'b0);
    observe(50, -5, 5, 32'd7, -5, first, pulses);
    total_cnt += 2;
    if (first !== 30) $display("FAIL set_running_delay: got %0d expected 30", first); else pass_cnt++;
    if (pulses !== 1) $display("FAIL set_running_pulses: got %0d expected 1", pulses); else pass_cnt++;
    arm(1'b0, '0, 1'b0);
    observe(90, -5, -5, '0, -5, first, pulses);
    total_cnt++;
    if (first !== 70) $display("FAIL new_stored_delay: got %0d expected 70", first); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int first, pulses;
    arm(1'b1, 32'd3, 1'b0);
    observe(60, -5, -5, '0, 10, first, pulses);
    total_cnt++;
    if (pulses !== 0) $display("FAIL abort_pulses: got %0d expected 0", pulses); else pass_cnt++;
    arm(1'b0, '0, 1'b0);
    observe(20, -5, -5, '0, -5, first, pulses);
    total_cnt++;
    if (first !== 1) $display("FAIL abort_stored_cleared: got %0d expected 1", first); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_pad();
    test_keyboard();
    test_kb_disabled_glitch();
    test_timer_basic();
    test_retrigger();
    test_set_while_running();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
